// File: rtl/dataflow_rx_if.sv
// Bundle of signals between the serial line side and the frame receiver.
// The master end drives the line and the parity option; the slave end is
// the receiver that returns the recovered word and its status flags.
interface dataflow_rx_if #(
    parameter int N = 8
);
    logic         rx;
    logic         parity_check;
    logic [N-1:0] D;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    modport master (
        output rx,
        output parity_check,
        input  D,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  parity_check,
        output D,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/dataflow_rx.sv
// Serial frame receiver. Detects a start bit on an idle-high line, samples
// each slot at its mid-bit point, collects n data bits LSB-first, checks an
// optional parity bit and the stop bit, then presents the word with a
// one-cycle valid pulse and error flags.
module dataflow_rx #(
    parameter int n                    = 8,
    parameter bit parity_type_even_odd = 1'b1,
    parameter int CPB                  = 1
) (
    input  logic         clk,
    input  logic         rst,
    dataflow_rx_if.slave bus
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;
    localparam int H  = (CPB - 1) / 2;
    localparam int HM1 = (H > 0) ? (H - 1) : 0;

    // Counter value at which a slot sample is taken once the start bit has
    // been confirmed: samples are then exactly CPB cycles apart.
    localparam logic [CW-1:0] CNT_LAST   = CW'(CPB - 1);
    // Counter value in START that lands on the mid-point of the start bit.
    // START is entered one cycle after detection, hence H-1.
    localparam logic [CW-1:0] START_LAST = CW'(HM1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(n - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [BW-1:0]   bit_q,       bit_d;
    logic [n-1:0]    shift_q,     shift_d;
    logic            p_q,         p_d;
    logic            par_flag_q,  par_flag_d;
    logic [n-1:0]    d_out_q,     d_out_d;
    logic            valid_q,     valid_d;
    logic            perr_q,      perr_d;
    logic            ferr_q,      ferr_d;

    logic            slot_sample;
    logic            exp_parity;

    // Mid-bit sample strobe for data, parity and stop slots.
    assign slot_sample = (cnt_q == CNT_LAST);

    // Parity bit the transmitter should have sent for the collected data.
    assign exp_parity = parity_type_even_odd ? (^shift_q) : ~(^shift_q);

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            p_q        <= 1'b0;
            par_flag_q <= 1'b0;
            d_out_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            p_q        <= p_d;
            par_flag_q <= par_flag_d;
            d_out_q    <= d_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        p_d        = p_q;
        par_flag_d = par_flag_q;
        d_out_d    = d_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!bus.rx) begin
                    p_d        = bus.parity_check;
                    shift_d    = '0;
                    par_flag_d = 1'b0;
                    // With H=0 the detection cycle is itself the start-bit
                    // sample and it already read 0, so the start is confirmed
                    // and the sequencer goes straight to the data slots.
                    state_d    = (H == 0) ? S_DATA : S_START;
                end
            end

            S_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    state_d = bus.rx ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (slot_sample) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = bus.rx;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = p_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_PARITY: begin
                if (slot_sample) begin
                    cnt_d      = '0;
                    par_flag_d = (bus.rx != exp_parity);
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (slot_sample) begin
                    cnt_d   = '0;
                    d_out_d = shift_q;
                    valid_d = 1'b1;
                    perr_d  = par_flag_q;
                    ferr_d  = ~bus.rx;
                    // A low stop bit means the line may be held in break;
                    // wait for it to go high before looking for a new start.
                    state_d = bus.rx ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (bus.rx) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign bus.D          = d_out_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    // The valid cycle is already back in IDLE, yet still counts as busy.
    assign bus.busy       = (state_q != S_IDLE) || valid_q;

endmodule

// File: tb/tb_dataflow_rx.sv
// Testbench for dataflow_rx: two receivers (CPB=1 and CPB=4, n=8, even
// parity) driven by directed frames, compared every cycle against a
// slot-arithmetic model, with literal latency/data checks on each frame.
module tb_dataflow_rx;

    logic clk = 1'b0;
    logic rst_v;
    logic rx_v [2];
    logic pc_v [2];

    always #5 clk = ~clk;

    dataflow_rx_if #(.N(8)) bus0 ();
    dataflow_rx_if #(.N(8)) bus1 ();

    assign bus0.rx           = rx_v[0];
    assign bus0.parity_check = pc_v[0];
    assign bus1.rx           = rx_v[1];
    assign bus1.parity_check = pc_v[1];

    dataflow_rx #(.n(8), .parity_type_even_odd(1'b1), .CPB(1)) u_dut0 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus0.slave)
    );

    dataflow_rx #(.n(8), .parity_type_even_odd(1'b1), .CPB(4)) u_dut1 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus1.slave)
    );

    logic [7:0] o_D     [2];
    logic       o_valid [2];
    logic       o_pe    [2];
    logic       o_fe    [2];
    logic       o_busy  [2];

    assign o_D[0] = bus0.D;          assign o_D[1] = bus1.D;
    assign o_valid[0] = bus0.valid;  assign o_valid[1] = bus1.valid;
    assign o_pe[0] = bus0.parity_err; assign o_pe[1] = bus1.parity_err;
    assign o_fe[0] = bus0.frame_err; assign o_fe[1] = bus1.frame_err;
    assign o_busy[0] = bus0.busy;    assign o_busy[1] = bus1.busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    ev_t dut_ev[$];
    ev_t mdl_ev[$];

    // Model state: 0 = waiting for start, 1 = inside a frame, 2 = line in break
    int         m_mode [2];
    int         m_t0   [2];
    int         m_p    [2];
    logic [7:0] m_data [2];
    logic       m_pbad [2];
    logic [7:0] e_D    [2];
    logic       e_valid[2];
    logic       e_pe   [2];
    logic       e_fe   [2];
    logic       e_busy [2];

    function automatic int cpb_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst %0d cyc %0d got %0h expected %0h", name, inst, cyc, got, exp);
        end
    endtask

    // Predict the outputs for the next cycle from the slot timing rules:
    // slot s is read at t0 + s*CPB + (CPB-1)/2.
    task automatic model_step(input int i);
        int  e, s, h, c;
        bit  nv;
        logic r;
        r  = rx_v[i];
        c  = cpb_of(i);
        h  = (c - 1) / 2;
        nv = 1'b0;
        e_pe[i] = 1'b0;
        e_fe[i] = 1'b0;
        if (rst_v) begin
            m_mode[i] = 0;
            e_D[i]    = 8'h00;
        end else if (m_mode[i] == 2) begin
            if (r) m_mode[i] = 0;
        end else begin
            if (m_mode[i] == 0 && r == 1'b0) begin
                m_mode[i] = 1;
                m_t0[i]   = cyc;
                m_p[i]    = pc_v[i] ? 1 : 0;
                m_data[i] = 8'h00;
                m_pbad[i] = 1'b0;
            end
            if (m_mode[i] == 1) begin
                e = cyc - m_t0[i];
                if (e >= h && ((e - h) % c) == 0) begin
                    s = (e - h) / c;
                    if (s == 0) begin
                        if (r) m_mode[i] = 0;
                    end else if (s <= 8) begin
                        m_data[i][s-1] = r;
                    end else if (m_p[i] == 1 && s == 9) begin
                        m_pbad[i] = (r != (^m_data[i]));
                    end else if (s == 9 + m_p[i]) begin
                        nv        = 1'b1;
                        e_D[i]    = m_data[i];
                        e_pe[i]   = m_pbad[i];
                        e_fe[i]   = ~r;
                        m_mode[i] = r ? 0 : 2;
                        mdl_ev.push_back('{i, cyc + 1, m_data[i], m_pbad[i], ~r});
                    end
                end
            end
        end
        e_valid[i] = nv;
        e_busy[i]  = (m_mode[i] != 0) || nv;
    endtask

    // One clock: update model with the inputs about to be sampled, clock,
    // then compare every output of both receivers mid-cycle.
    task automatic tick();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("valid", i, 32'(o_valid[i]), 32'(e_valid[i]));
            chk("busy", i, 32'(o_busy[i]), 32'(e_busy[i]));
            chk("D", i, 32'(o_D[i]), 32'(e_D[i]));
            chk("parity_err", i, 32'(o_pe[i]), 32'(e_pe[i]));
            chk("frame_err", i, 32'(o_fe[i]), 32'(e_fe[i]));
            if (o_valid[i] === 1'b1) dut_ev.push_back('{i, cyc, o_D[i], o_pe[i], o_fe[i]});
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) tick();
    endtask

    // Send one frame on instance i; parity_check is toggled after the start
    // cycle to show mid-frame changes are ignored.
    task automatic send_frame(input int i, input logic [7:0] d, input bit pen,
                              input bit pbit, input bit sbit, output int t0);
        logic bits [11];
        int   nb;
        logic pc0;
        pc0 = pen;
        pc_v[i] = pc0;
        t0 = cyc;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        nb = 9;
        if (pen) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = sbit;
        nb++;
        for (int s = 0; s < nb; s++) begin
            rx_v[i] = bits[s];
            for (int c = 0; c < cpb_of(i); c++) begin
                tick();
                pc_v[i] = ~pc0;
            end
        end
        pc_v[i] = pc0;
    endtask

    task automatic expect_ev(input string name, input int inst, input int t0, input int lat,
                             input logic [7:0] d, input logic pe, input logic fe);
        ev_t ev;
        for (int q = 0; q < 2; q++) begin
            if ((q == 0 ? dut_ev.size() : mdl_ev.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL %s %s no valid pulse seen, expected one at cyc %0d", name,
                         (q == 0) ? "dut" : "model", t0 + lat);
            end else begin
                ev = (q == 0) ? dut_ev.pop_front() : mdl_ev.pop_front();
                chk({name, (q == 0) ? "_dut_inst" : "_mdl_inst"}, inst, 32'(ev.inst), 32'(inst));
                chk({name, (q == 0) ? "_dut_latency" : "_mdl_latency"}, inst, 32'(ev.cyc - t0), 32'(lat));
                chk({name, (q == 0) ? "_dut_D" : "_mdl_D"}, inst, 32'(ev.d), 32'(d));
                chk({name, (q == 0) ? "_dut_perr" : "_mdl_perr"}, inst, 32'(ev.pe), 32'(pe));
                chk({name, (q == 0) ? "_dut_ferr" : "_mdl_ferr"}, inst, 32'(ev.fe), 32'(fe));
            end
        end
    endtask

    task automatic expect_no_ev(input string name);
        chk({name, "_dut_events"}, 0, 32'(dut_ev.size()), 32'd0);
        chk({name, "_mdl_events"}, 0, 32'(mdl_ev.size()), 32'd0);
        dut_ev.delete();
        mdl_ev.delete();
    endtask

    initial begin
        int t0, t1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_t0[i] = 0; m_p[i] = 0; m_data[i] = 8'h00; m_pbad[i] = 1'b0;
            e_D[i] = 8'h00; e_valid[i] = 1'b0; e_pe[i] = 1'b0; e_fe[i] = 1'b0; e_busy[i] = 1'b0;
            pc_v[i] = 1'b1;
            rx_v[i] = 1'b0;
        end
        rst_v = 1'b1;

        // Reset with the line low: everything stays cleared.
        idle(2);
        chk("reset_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("reset_busy", 1, 32'(o_busy[1]), 32'd0);
        chk("reset_D", 0, 32'(o_D[0]), 32'd0);
        rst_v = 1'b0;
        rx_v[0] = 1'b1;
        rx_v[1] = 1'b1;
        idle(3);
        chk("release_busy", 0, 32'(o_busy[0]), 32'd0);
        expect_no_ev("reset");

        // Good frame with even parity: 0xA5 has four ones, parity bit 0.
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1, t0);
        idle(3);
        expect_ev("good_a5", 0, t0, 11, 8'hA5, 1'b0, 1'b0);

        // 0x01 needs parity bit 1 for even parity; send 0.
        send_frame(0, 8'h01, 1'b1, 1'b0, 1'b1, t0);
        idle(3);
        expect_ev("perr_01", 0, t0, 11, 8'h01, 1'b1, 1'b0);

        // No parity, stop bit low, line held low for 5 more cycles.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, t0);
        rx_v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("break_busy", 0, 32'(o_busy[0]), 32'd1);
        end
        expect_ev("ferr_3c", 0, t0, 10, 8'h3C, 1'b0, 1'b1);
        rx_v[0] = 1'b1;
        tick();
        tick();
        chk("break_release_busy", 0, 32'(o_busy[0]), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, t0);
        idle(3);
        expect_ev("after_break_81", 0, t0, 10, 8'h81, 1'b0, 1'b0);

        // CPB=4: one-cycle low glitch must not start a frame.
        rx_v[1] = 1'b0;
        tick();
        rx_v[1] = 1'b1;
        idle(6);
        chk("glitch_busy", 1, 32'(o_busy[1]), 32'd0);
        expect_no_ev("glitch");
        send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
        idle(4);
        expect_ev("cpb4_5a", 1, t0, 38, 8'h5A, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap.
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, t0);
        send_frame(0, 8'hEE, 1'b0, 1'b0, 1'b1, t1);
        idle(2);
        chk("b2b_gap", 0, 32'(t1 - t0), 32'd10);
        expect_ev("b2b_11", 0, t0, 10, 8'h11, 1'b0, 1'b0);
        expect_ev("b2b_ee", 0, t1, 10, 8'hEE, 1'b0, 1'b0);

        // Third frame 0xFF cut by reset at data bit 3.
        pc_v[0] = 1'b0;
        rx_v[0] = 1'b0;
        tick();
        rx_v[0] = 1'b1;
        idle(3);
        rst_v = 1'b1;
        idle(2);
        rst_v = 1'b0;
        chk("midrst_D", 0, 32'(o_D[0]), 32'd0);
        chk("midrst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("midrst_valid", 0, 32'(o_valid[0]), 32'd0);
        idle(8);
        expect_no_ev("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataflow_rx.md
# dataflow_rx

Serial frame receiver: the receive end of the Tx link. It watches the serial line `rx` and detects a start bit. It then shifts in `n` data bits LSB-first, checks an optional parity bit and the stop bit, and presents the recovered word on `D` with a one-cycle `valid` pulse plus error flags. It sits in the Rx module next to the transmitter and consumes the same frame format.

## Interface
- `n`, 8: data bits per frame.
- `parity_type_even_odd`, 1'b1: 1 = even parity, 0 = odd parity.
- `CPB`, 1: clock cycles per serial bit. Must be ≥1. 1 = one bit per `clk`, matching the transmitter.
- `clk`  input  1: single clock; all logic on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `rx`  input  1: serial line. Idle high. Synchronous to `clk`.
- `parity_check`  input  1: 1 = frame carries a parity bit. Sampled at start detection.
- `D`  output  n: last received word; holds until the next `valid`.
- `valid`  output  1: one-cycle pulse when a frame completes, with or without error.
- `parity_err`  output  1: parity mismatch on the frame flagged by `valid`.
- `frame_err`  output  1: stop bit sampled 0 on the frame flagged by `valid`.
- `busy`  output  1: high from start detection until return to IDLE.

## Operation
- Frame layout: start (0), data[0]..data[n-1], parity (only if `parity_check`=1), stop (1). Let p = latched `parity_check` (0/1).
- Slot numbering: start = slot 0, data bit k = slot k+1, parity = slot n+1, stop = slot n+1+p.
- Mid-bit offset H = (CPB-1)/2, integer division. Slot s is sampled at cycle t0 + s·CPB + H, where t0 is the cycle IDLE sees `rx`=0.
- Counters: sample counter 0..CPB-1 (width clog2(CPB), min 1); bit counter 0..n-1.
- States:
  - IDLE: `rx`=0 → START. Latch p and clear the shift register. `busy` goes high next cycle.
  - START: at the slot-0 sample (for H=0 this is the detection cycle itself): `rx`=0 → DATA; `rx`=1 → IDLE (glitch). A glitch produces no `valid` and no error.
  - DATA: shift `rx` into bit k at each data sample. After bit n-1 → PARITY if p=1, else STOP.
  - PARITY: compare the sampled bit with the expected value. Even: XOR of data bits. Odd: its complement. Mismatch sets an internal parity flag.
  - STOP: sample `rx`. Next cycle: load `D`, pulse `valid`, drive `parity_err`/`frame_err`. Go to IDLE if stop = 1; go to WAIT_IDLE if stop = 0.
  - WAIT_IDLE: stay until `rx`=1, then IDLE. This blocks re-triggering on a held-low (break) line.
- `parity_err` and `frame_err` are valid only in the `valid` cycle. They are 0 at all other times.
- Changes to `parity_check` mid-frame are ignored.

## Timing
- Reset values: `D`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state = IDLE, counters = 0.
- Reset mid-frame: the partial frame is discarded with no `valid`. Any frame still on the line is ignored until `rx` is seen 0 again from IDLE.
- Latency: `valid` asserts at t0 + (n+1+p)·CPB + H + 1. For n=8, CPB=1, p=1: t0+11.
- Back-to-back frames: the `valid` cycle is already IDLE. A start bit present in that cycle is detected, so a new start at stop+1 slot is accepted with no gap.
- `busy` is high from t0+1 through the `valid` cycle. It stays high through WAIT_IDLE.
- `rst` has priority over every other input in the same cycle.

## Test plan
- Reset: `rst`=1 for 2 cycles with `rx`=0 → all outputs 0, state IDLE. Release with `rx`=1 → `busy` stays 0.
- Good frame, n=8, CPB=1, even, `parity_check`=1, 0xA5, parity bit 0, stop 1 → `valid` at t0+11, `D`=0xA5, both error flags 0.
- Parity error: 0x01 sent with parity bit 0 (even expects 1) → `valid` at t0+11, `D`=0x01, `parity_err`=1, `frame_err`=0.
- Frame error, no parity: 0x3C with stop=0 and `rx` held 0 for 5 more cycles → `valid` at t0+10, `D`=0x3C, `frame_err`=1. `busy` stays high until `rx`=1. Then a 0x81 frame is received correctly.
- CPB=4 (H=1): 1-cycle low glitch → no `valid`, `busy` back to 0. Then a full 0x5A frame with no parity → samples at t0+4s+1, `valid` at t0+38, `D`=0x5A.
- Back-to-back 0x11 then 0xEE, CPB=1, no parity → two `valid` pulses 10 cycles apart. Then `rst` asserted at data bit 3 of a third frame → no third `valid`, outputs return to reset values.
